// File: rtl/proc_pkg.sv
// Constants and state encoding shared by the datapath control blocks.
package proc_pkg;
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WBACK} seq_state_t;

  localparam int WORD_BYTES = 4;
  localparam int PC_IDX     = 15;
  localparam int NREG       = 16;
  localparam int RA_W       = 4;
endpackage

// File: rtl/lowest_set_bit.sv
// Priority encoder: index of the lowest set bit in vec, plus a valid flag.
module lowest_set_bit #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: one register per cycle, then optional base writeback.
// state  | meaning
// IDLE   | waiting for start, all strobes low
// XFER   | servicing the lowest remaining register of the captured list
// WBACK  | single cycle writing the final base to rn (may be suppressed)
module ldm_stm_sequencer #(
  parameter int DATA_W = 32,
  parameter int NREG   = proc_pkg::NREG,
  parameter int RA_W   = proc_pkg::RA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              wback,
  input  logic [RA_W-1:0]   rn,
  input  logic [DATA_W-1:0] base,
  input  logic [NREG-1:0]   reg_list,
  output logic [RA_W-1:0]   ra,
  input  logic [DATA_W-1:0] rd,
  output logic [RA_W-1:0]   wa,
  output logic              we,
  output logic [DATA_W-1:0] wd,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wd,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);
  import proc_pkg::*;

  localparam int CNT_W = $clog2(NREG + 1);
  localparam logic [DATA_W-1:0] STEP = DATA_W'(WORD_BYTES);

  seq_state_t        state_q, state_d;
  logic [NREG-1:0]   list_q;
  logic [DATA_W-1:0] addr_q, final_q;
  logic              is_load_q, wback_q, wr_base_q;
  logic [RA_W-1:0]   rn_q;

  logic [CNT_W-1:0]  n_cnt;
  logic [DATA_W-1:0] span, first_addr, final_addr;
  logic [RA_W-1:0]   cur_idx;
  logic              cur_valid;
  logic [NREG-1:0]   rest;

  always_comb begin
    n_cnt = '0;
    for (int i = 0; i < NREG; i++) n_cnt = n_cnt + CNT_W'(reg_list[i]);
  end

  assign span = DATA_W'(n_cnt) * STEP;

  always_comb begin
    if (up) first_addr = pre ? base + STEP : base;
    else    first_addr = pre ? base - span : base - span + STEP;
    final_addr = up ? base + span : base - span;
  end

  lowest_set_bit #(.N(NREG), .W(RA_W)) u_lsb (
    .vec   (list_q),
    .idx   (cur_idx),
    .valid (cur_valid)
  );

  assign rest = list_q & ~(NREG'(1) << cur_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list_q    <= '0;
      addr_q    <= '0;
      final_q   <= '0;
      is_load_q <= 1'b0;
      wback_q   <= 1'b0;
      wr_base_q <= 1'b0;
      rn_q      <= '0;
    end else if (state_q == S_IDLE && start) begin
      list_q    <= reg_list;
      addr_q    <= first_addr;
      final_q   <= final_addr;
      is_load_q <= is_load;
      wback_q   <= wback;
      // A loaded base register keeps its loaded value rather than the writeback.
      wr_base_q <= wback && !(is_load && reg_list[rn]);
      rn_q      <= rn;
    end else if (state_q == S_XFER) begin
      list_q <= rest;
      addr_q <= addr_q + STEP;
    end
  end

  always_comb begin
    state_d   = state_q;
    ra        = '0;
    wa        = '0;
    we        = 1'b0;
    wd        = '0;
    pc_we     = 1'b0;
    pc_wd     = '0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (reg_list != '0) ? S_XFER : S_WBACK;
      end
      S_XFER: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        if (cur_valid) begin
          if (!is_load_q) begin
            ra        = cur_idx;
            mem_we    = 1'b1;
            mem_wdata = rd;
          end else if (cur_idx == RA_W'(PC_IDX)) begin
            pc_we = 1'b1;
            pc_wd = mem_rdata;
          end else begin
            we = 1'b1;
            wa = cur_idx;
            wd = mem_rdata;
          end
        end
        if (rest == '0) begin
          state_d = wback_q ? S_WBACK : S_IDLE;
          done    = !wback_q;
        end
      end
      S_WBACK: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
        if (wr_base_q) begin
          we = 1'b1;
          wa = rn_q;
          wd = final_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with simple combinational register-file and memory models.
module tb_ldm_stm_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0, up = 1'b0, pre = 1'b0, wback = 1'b0;
  logic [3:0]  rn = '0;
  logic [31:0] base = '0;
  logic [15:0] reg_list = '0;
  logic [3:0]  ra, wa;
  logic [31:0] rd, wd, pc_wd, mem_addr, mem_wdata, mem_rdata;
  logic        we, pc_we, mem_we, busy, done;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] rdf(input logic [3:0] r);
    return {28'hBEEF000, r};
  endfunction

  assign mem_rdata = memf(mem_addr);
  assign rd        = rdf(ra);

  ldm_stm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .up(up), .pre(pre),
    .wback(wback), .rn(rn), .base(base), .reg_list(reg_list), .ra(ra), .rd(rd),
    .wa(wa), .we(we), .wd(wd), .pc_we(pc_we), .pc_wd(pc_wd), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  // Returns at the falling edge of the first busy cycle.
  task automatic issue(input logic ld, input logic u, input logic p, input logic wb,
                       input logic [3:0] r, input logic [31:0] b, input logic [15:0] l);
    @(negedge clk);
    is_load = ld; up = u; pre = p; wback = wb; rn = r; base = b; reg_list = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    nchk++;
    if ({busy, done, we, pc_we, mem_we} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_strobes: got %b want 00000", {busy, done, we, pc_we, mem_we});
    end
    nchk++;
    if ({ra, wa, wd, pc_wd, mem_addr, mem_wdata} !== '0) begin
      nerr++;
      $display("FAIL reset_values: ra=%h wa=%h wd=%h pc_wd=%h mem_addr=%h mem_wdata=%h want all 0",
               ra, wa, wd, pc_wd, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stmia;
    issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h100, 16'h000E);
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if ({busy, done, we, pc_we, mem_we} !== 5'b10001 || mem_addr !== 32'h100 + 32'(4 * i)
          || ra !== 4'(i + 1) || mem_wdata !== rdf(4'(i + 1))) begin
        nerr++;
        $display("FAIL stmia_xfer%0d: flags=%b addr=%h ra=%h wdata=%h want 10001 %h %h %h", i,
                 {busy, done, we, pc_we, mem_we}, mem_addr, ra, mem_wdata,
                 32'h100 + 32'(4 * i), 4'(i + 1), rdf(4'(i + 1)));
      end
      @(negedge clk);
    end
    nchk++;
    if ({busy, done, we, pc_we, mem_we} !== 5'b11100 || wa !== 4'd13 || wd !== 32'h10C) begin
      nerr++;
      $display("FAIL stmia_wback: flags=%b wa=%h wd=%h want 11100 d 10c",
               {busy, done, we, pc_we, mem_we}, wa, wd);
    end
    @(negedge clk);
    nchk++;
    if ({busy, done} !== 2'b00) begin
      nerr++;
      $display("FAIL stmia_end: busy/done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_ldmdb;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 32'h200, 16'h8001);
    nchk++;
    if ({busy, done, we, pc_we, mem_we} !== 5'b10100 || wa !== 4'd0
        || mem_addr !== 32'h1F8 || wd !== memf(32'h1F8)) begin
      nerr++;
      $display("FAIL ldmdb_r0: flags=%b wa=%h addr=%h wd=%h want 10100 0 1f8 %h",
               {busy, done, we, pc_we, mem_we}, wa, mem_addr, wd, memf(32'h1F8));
    end
    @(negedge clk);
    nchk++;
    if ({busy, done, we, pc_we, mem_we} !== 5'b11010 || mem_addr !== 32'h1FC
        || pc_wd !== memf(32'h1FC)) begin
      nerr++;
      $display("FAIL ldmdb_pc: flags=%b addr=%h pc_wd=%h want 11010 1fc %h",
               {busy, done, we, pc_we, mem_we}, mem_addr, pc_wd, memf(32'h1FC));
    end
    @(negedge clk);
    nchk++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL ldmdb_end: busy=%b want 0", busy);
    end
  endtask

  task automatic test_empty;
    issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 32'h40, 16'h0000);
    nchk++;
    if ({busy, done, we, pc_we, mem_we} !== 5'b11100 || wa !== 4'd4 || wd !== 32'h40
        || mem_addr !== 32'h0) begin
      nerr++;
      $display("FAIL empty_wb: flags=%b wa=%h wd=%h addr=%h want 11100 4 40 0",
               {busy, done, we, pc_we, mem_we}, wa, wd, mem_addr);
    end
    @(negedge clk);
    nchk++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL empty_wb_end: busy=%b want 0", busy);
    end
    issue(1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 32'h40, 16'h0000);
    nchk++;
    if ({busy, done, we, pc_we, mem_we} !== 5'b11000) begin
      nerr++;
      $display("FAIL empty_nowb: flags=%b want 11000", {busy, done, we, pc_we, mem_we});
    end
    @(negedge clk);
  endtask

  task automatic test_ldmia_suppress;
    issue(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0, 16'h0006);
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if ({busy, done, we, pc_we, mem_we} !== 5'b10100 || wa !== 4'(i + 1)
          || wd !== memf(32'(4 * i))) begin
        nerr++;
        $display("FAIL ldmia_r%0d: flags=%b wa=%h wd=%h want 10100 %h %h", i + 1,
                 {busy, done, we, pc_we, mem_we}, wa, wd, 4'(i + 1), memf(32'(4 * i)));
      end
      @(negedge clk);
    end
    nchk++;
    if ({busy, done, we, pc_we, mem_we} !== 5'b11000) begin
      nerr++;
      $display("FAIL ldmia_suppressed: flags=%b want 11000", {busy, done, we, pc_we, mem_we});
    end
    @(negedge clk);
    nchk++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL ldmia_end: busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h10, 16'h0003);
    nchk++;
    if ({busy, done, mem_we} !== 3'b101 || mem_addr !== 32'hC || ra !== 4'd0) begin
      nerr++;
      $display("FAIL stmda_r0: flags=%b addr=%h ra=%h want 101 c 0", {busy, done, mem_we}, mem_addr, ra);
    end
    @(negedge clk);
    nchk++;
    if ({busy, done, mem_we} !== 3'b111 || mem_addr !== 32'h10 || ra !== 4'd1
        || mem_wdata !== rdf(4'd1)) begin
      nerr++;
      $display("FAIL stmda_r1: flags=%b addr=%h ra=%h wdata=%h want 111 10 1 %h",
               {busy, done, mem_we}, mem_addr, ra, mem_wdata, rdf(4'd1));
    end
    // issue drives start in the cycle right after done
    issue(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 32'h20, 16'h0001);
    nchk++;
    if ({busy, done, we} !== 3'b111 || wa !== 4'd0 || wd !== memf(32'h20)) begin
      nerr++;
      $display("FAIL b2b_load: flags=%b wa=%h wd=%h want 111 0 %h", {busy, done, we}, wa, wd, memf(32'h20));
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_and_reset;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 32'h300, 16'h00F0);
    @(negedge clk);
    base = 32'h900; reg_list = 16'h0001; is_load = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nchk++;
    if ({busy, mem_we, we} !== 3'b110 || mem_addr !== 32'h308 || ra !== 4'd6) begin
      nerr++;
      $display("FAIL ignore_start: flags=%b addr=%h ra=%h want 110 308 6", {busy, mem_we, we}, mem_addr, ra);
    end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if ({busy, done, we, pc_we, mem_we} !== 5'b0 || mem_addr !== 32'h0) begin
      nerr++;
      $display("FAIL async_reset: flags=%b addr=%h want 00000 0", {busy, done, we, pc_we, mem_we}, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'h500, 16'h0001);
    nchk++;
    if ({busy, done, mem_we} !== 3'b101 || mem_addr !== 32'h500 || mem_wdata !== rdf(4'd0)) begin
      nerr++;
      $display("FAIL post_reset_xfer: flags=%b addr=%h wdata=%h want 101 500 %h",
               {busy, done, mem_we}, mem_addr, mem_wdata, rdf(4'd0));
    end
    @(negedge clk);
    nchk++;
    if ({busy, done, we} !== 3'b111 || wa !== 4'd1 || wd !== 32'h504) begin
      nerr++;
      $display("FAIL post_reset_wb: flags=%b wa=%h wd=%h want 111 1 504", {busy, done, we}, wa, wd);
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && ((we && pc_we) || (we && mem_we) || (pc_we && mem_we))) begin
      nerr++;
      $display("FAIL exclusive_strobes: we=%b pc_we=%b mem_we=%b", we, pc_we, mem_we);
    end
  end

  initial begin
    test_reset;
    test_stmia;
    test_ldmdb;
    test_empty;
    test_ldmia_suppress;
    test_back_to_back;
    test_ignore_and_reset;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
